iob_picorv32_bus_merge: RTL and testbench

//   Merges the PicoRV32 ibus and dbus IOb ports into one IOb manager port for single-port memory/interconnect.

---
 rtl/iob_picorv32_bus_merge.sv | 184 ++++++++++++++++++
 tb/tb_iob_picorv32_bus_merge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_picorv32_bus_merge.sv
// Merges the PicoRV32 instruction and data IOb buses onto one IOb manager port.
// Round-robin arbitration, grant locked on stall, in-order route FIFO for read responses.
module iob_picorv32_bus_merge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,

  input  logic                ibus_iob_valid_i,
  input  logic [ADDR_W-1:0]   ibus_iob_addr_i,
  input  logic [DATA_W-1:0]   ibus_iob_wdata_i,
  input  logic [DATA_W/8-1:0] ibus_iob_wstrb_i,
  input  logic                ibus_iob_rready_i,
  output logic                ibus_iob_ready_o,
  output logic                ibus_iob_rvalid_o,
  output logic [DATA_W-1:0]   ibus_iob_rdata_o,

  input  logic                dbus_iob_valid_i,
  input  logic [ADDR_W-1:0]   dbus_iob_addr_i,
  input  logic [DATA_W-1:0]   dbus_iob_wdata_i,
  input  logic [DATA_W/8-1:0] dbus_iob_wstrb_i,
  input  logic                dbus_iob_rready_i,
  output logic                dbus_iob_ready_o,
  output logic                dbus_iob_rvalid_o,
  output logic [DATA_W-1:0]   dbus_iob_rdata_o,

  output logic                mem_iob_valid_o,
  output logic [ADDR_W-1:0]   mem_iob_addr_o,
  output logic [DATA_W-1:0]   mem_iob_wdata_o,
  output logic [DATA_W/8-1:0] mem_iob_wstrb_o,
  output logic                mem_iob_rready_o,
  input  logic                mem_iob_ready_i,
  input  logic                mem_iob_rvalid_i,
  input  logic [DATA_W-1:0]   mem_iob_rdata_i,

  output logic                err_o
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic BUS_I = 1'b0;
  localparam logic BUS_D = 1'b1;

  typedef enum logic [1:0] {FREE, LOCK_I, LOCK_D} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_vld;
  logic               grant_id;
  logic               req_valid;
  logic               accept;
  logic               push;
  logic               pop;
  logic               empty;
  logic               full;
  logic               head_id;

  logic               route_q [MAX_OUT];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(MAX_OUT));
  assign head_id = route_q[rd_ptr_q];

  // Arbitration and lock FSM; full only gates new grants from FREE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_vld    = 1'b0;
    grant_id     = BUS_I;
    unique case (state_q)
      FREE: begin
        if (!full) begin
          if (ibus_iob_valid_i && dbus_iob_valid_i) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant_q;
          end else if (ibus_iob_valid_i) begin
            grant_vld = 1'b1;
            grant_id  = BUS_I;
          end else if (dbus_iob_valid_i) begin
            grant_vld = 1'b1;
            grant_id  = BUS_D;
          end
        end
      end
      LOCK_I: begin
        grant_vld = 1'b1;
        grant_id  = BUS_I;
      end
      LOCK_D: begin
        grant_vld = 1'b1;
        grant_id  = BUS_D;
      end
      default: state_d = FREE;
    endcase
    if (!rst_n_i) begin
      grant_vld = 1'b0;
    end
    if (grant_vld) begin
      if (mem_iob_ready_i) begin
        state_d      = FREE;
        last_grant_d = grant_id;
      end else begin
        state_d = (grant_id == BUS_D) ? LOCK_D : LOCK_I;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= FREE;
      last_grant_q <= BUS_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req_valid        = (grant_id == BUS_D) ? dbus_iob_valid_i : ibus_iob_valid_i;
  assign mem_iob_valid_o  = grant_vld & req_valid;
  assign mem_iob_addr_o   = (grant_id == BUS_D) ? dbus_iob_addr_i  : ibus_iob_addr_i;
  assign mem_iob_wdata_o  = (grant_id == BUS_D) ? dbus_iob_wdata_i : ibus_iob_wdata_i;
  assign mem_iob_wstrb_o  = (grant_id == BUS_D) ? dbus_iob_wstrb_i : ibus_iob_wstrb_i;
  assign ibus_iob_ready_o = grant_vld & (grant_id == BUS_I) & mem_iob_ready_i;
  assign dbus_iob_ready_o = grant_vld & (grant_id == BUS_D) & mem_iob_ready_i;

  assign accept = mem_iob_valid_o & mem_iob_ready_i;
  assign push   = accept & (mem_iob_wstrb_o == '0);

  // An empty FIFO still accepts rvalid so a stray response cannot stall the memory.
  always_comb begin
    mem_iob_rready_o = 1'b0;
    if (rst_n_i) begin
      if (empty) begin
        mem_iob_rready_o = 1'b1;
      end else begin
        mem_iob_rready_o = (head_id == BUS_D) ? dbus_iob_rready_i : ibus_iob_rready_i;
      end
    end
  end

  assign ibus_iob_rvalid_o = rst_n_i & !empty & (head_id == BUS_I) & mem_iob_rvalid_i;
  assign dbus_iob_rvalid_o = rst_n_i & !empty & (head_id == BUS_D) & mem_iob_rvalid_i;
  assign ibus_iob_rdata_o  = mem_iob_rdata_i;
  assign dbus_iob_rdata_o  = mem_iob_rdata_i;

  assign pop = mem_iob_rvalid_i & mem_iob_rready_o & !empty;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_o    <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        route_q[i] <= BUS_I;
      end
    end else begin
      if (push) begin
        route_q[wr_ptr_q] <= grant_id;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (mem_iob_rvalid_i && empty) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iob_picorv32_bus_merge.sv
// Directed bench for iob_picorv32_bus_merge: stimulus pushes expected requests and
// responses into queues, a negedge monitor pops them on every DUT handshake.
module tb_iob_picorv32_bus_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ibus_valid, ibus_rready, ibus_ready, ibus_rvalid;
  logic [31:0] ibus_addr, ibus_wdata, ibus_rdata;
  logic [3:0]  ibus_wstrb;
  logic        dbus_valid, dbus_rready, dbus_ready, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_wstrb;
  logic        mem_valid, mem_rready, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        err;

  typedef struct packed {logic [31:0] addr; logic [3:0] wstrb;} req_t;
  typedef struct packed {logic bus; logic [31:0] data;} rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  iob_picorv32_bus_merge #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ibus_iob_valid_i(ibus_valid), .ibus_iob_addr_i(ibus_addr), .ibus_iob_wdata_i(ibus_wdata),
    .ibus_iob_wstrb_i(ibus_wstrb), .ibus_iob_rready_i(ibus_rready), .ibus_iob_ready_o(ibus_ready),
    .ibus_iob_rvalid_o(ibus_rvalid), .ibus_iob_rdata_o(ibus_rdata),
    .dbus_iob_valid_i(dbus_valid), .dbus_iob_addr_i(dbus_addr), .dbus_iob_wdata_i(dbus_wdata),
    .dbus_iob_wstrb_i(dbus_wstrb), .dbus_iob_rready_i(dbus_rready), .dbus_iob_ready_o(dbus_ready),
    .dbus_iob_rvalid_o(dbus_rvalid), .dbus_iob_rdata_o(dbus_rdata),
    .mem_iob_valid_o(mem_valid), .mem_iob_addr_o(mem_addr), .mem_iob_wdata_o(mem_wdata),
    .mem_iob_wstrb_o(mem_wstrb), .mem_iob_rready_o(mem_rready), .mem_iob_ready_i(mem_ready),
    .mem_iob_rvalid_i(mem_rvalid), .mem_iob_rdata_i(mem_rdata),
    .err_o(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every handshake on the DUT outputs consumes one expectation.
  always @(negedge clk) begin
    req_t r;
    rsp_t s;
    if (mem_valid && mem_ready) begin
      if (exp_req.size() == 0) begin
        n_total++;
        $display("FAIL mem_req_unexpected: got addr %h expected no request", mem_addr);
      end else begin
        r = exp_req.pop_front();
        chk("mem_addr", mem_addr, r.addr);
        chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, r.wstrb});
      end
    end
    if ((ibus_rvalid && ibus_rready) || (dbus_rvalid && dbus_rready)) begin
      if (exp_rsp.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got ibus=%b dbus=%b data %h expected none",
                 ibus_rvalid, dbus_rvalid, mem_rdata);
      end else begin
        s = exp_rsp.pop_front();
        chkb("rsp_ibus_rvalid", ibus_rvalid, ~s.bus);
        chkb("rsp_dbus_rvalid", dbus_rvalid, s.bus);
        chk("rsp_rdata", s.bus ? dbus_rdata : ibus_rdata, s.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ibus_valid = 0; ibus_addr = '0; ibus_wdata = '0; ibus_wstrb = '0; ibus_rready = 1'b1;
    dbus_valid = 0; dbus_addr = '0; dbus_wdata = '0; dbus_wstrb = '0; dbus_rready = 1'b1;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;

    // Reset: outputs stay quiet even with live inputs
    step(); step();
    ibus_valid = 1; ibus_addr = 32'h123; mem_ready = 1; mem_rvalid = 1;
    sample();
    chkb("rst_mem_valid", mem_valid, 1'b0);
    chkb("rst_ibus_ready", ibus_ready, 1'b0);
    chkb("rst_ibus_rvalid", ibus_rvalid, 1'b0);
    chkb("rst_dbus_rvalid", dbus_rvalid, 1'b0);
    step();
    ibus_valid = 0; mem_ready = 0; mem_rvalid = 0; rst_n = 1;
    sample();
    chkb("rst_err", err, 1'b0);

    // 1: ibus read, response routed to ibus only
    step();
    ibus_valid = 1; ibus_addr = 32'h100; ibus_wstrb = 4'h0; mem_ready = 1;
    exp_req.push_back('{32'h100, 4'h0});
    sample();
    chkb("t1_ibus_ready", ibus_ready, 1'b1);
    chkb("t1_dbus_ready", dbus_ready, 1'b0);
    step();
    ibus_valid = 0; mem_ready = 0;
    step();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    exp_rsp.push_back('{1'b0, 32'hDEADBEEF});
    sample();
    chkb("t1_ibus_rvalid", ibus_rvalid, 1'b1);
    chkb("t1_dbus_rvalid", dbus_rvalid, 1'b0);
    step();
    mem_rvalid = 0;
    sample();
    chkb("t1_rvalid_one_cycle", ibus_rvalid, 1'b0);

    // 2: simultaneous ibus read / dbus write after reset; ibus wins first
    step(); rst_n = 0;
    step(); rst_n = 1;
    ibus_valid = 1; ibus_addr = 32'h0; ibus_wstrb = 4'h0;
    dbus_valid = 1; dbus_addr = 32'h80; dbus_wstrb = 4'hF; dbus_wdata = 32'hCAFE;
    mem_ready = 1;
    exp_req.push_back('{32'h0, 4'h0});
    exp_req.push_back('{32'h80, 4'hF});
    sample();
    chkb("t2_ibus_ready", ibus_ready, 1'b1);
    chkb("t2_dbus_ready", dbus_ready, 1'b0);
    step();
    ibus_valid = 0;
    sample();
    chkb("t2_dbus_ready", dbus_ready, 1'b1);
    chk("t2_wdata", mem_wdata, 32'hCAFE);
    step();
    dbus_valid = 0; dbus_wstrb = 4'h0; mem_ready = 0;
    step();
    mem_rvalid = 1; mem_rdata = 32'h55;
    exp_rsp.push_back('{1'b0, 32'h55});
    step();
    mem_rvalid = 0;
    sample();
    chkb("t2_err", err, 1'b0);

    // 3: dbus read stalled 3 cycles, ibus waits then is granted
    step();
    dbus_valid = 1; dbus_addr = 32'h40;
    sample();
    chkb("t3_mem_valid", mem_valid, 1'b1);
    chk("t3_addr0", mem_addr, 32'h40);
    step();
    ibus_valid = 1; ibus_addr = 32'h200;
    sample();
    chk("t3_addr1", mem_addr, 32'h40);
    chkb("t3_ibus_ready1", ibus_ready, 1'b0);
    step();
    sample();
    chk("t3_addr2", mem_addr, 32'h40);
    chkb("t3_ibus_ready2", ibus_ready, 1'b0);
    step();
    mem_ready = 1;
    exp_req.push_back('{32'h40, 4'h0});
    sample();
    chkb("t3_dbus_ready", dbus_ready, 1'b1);
    chkb("t3_ibus_ready3", ibus_ready, 1'b0);
    step();
    dbus_valid = 0;
    exp_req.push_back('{32'h200, 4'h0});
    sample();
    chkb("t3_ibus_granted", ibus_ready, 1'b1);

    // 4: two reads outstanding -> blocked; one response frees a slot next cycle
    step();
    ibus_valid = 0; dbus_valid = 1; dbus_addr = 32'h300;
    sample();
    chkb("t4_full_ready", dbus_ready, 1'b0);
    chkb("t4_full_valid", mem_valid, 1'b0);
    step();
    mem_rvalid = 1; mem_rdata = 32'hA1;
    exp_rsp.push_back('{1'b1, 32'hA1});
    sample();
    chkb("t4_no_bypass_ready", dbus_ready, 1'b0);
    chkb("t4_no_bypass_valid", mem_valid, 1'b0);
    step();
    mem_rvalid = 0;
    exp_req.push_back('{32'h300, 4'h0});
    sample();
    chkb("t4_accept_after_pop", dbus_ready, 1'b1);
    step();
    dbus_valid = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hA2;
    exp_rsp.push_back('{1'b0, 32'hA2});
    step();
    mem_rdata = 32'hA3;
    exp_rsp.push_back('{1'b1, 32'hA3});
    step();
    mem_rvalid = 0;

    // 5: in-order routing and dbus backpressure
    ibus_valid = 1; ibus_addr = 32'h500;
    dbus_valid = 1; dbus_addr = 32'h600; mem_ready = 1;
    exp_req.push_back('{32'h500, 4'h0});
    exp_req.push_back('{32'h600, 4'h0});
    sample();
    chkb("t5_rr_ibus", ibus_ready, 1'b1);
    step();
    ibus_valid = 0;
    sample();
    chkb("t5_dbus_ready", dbus_ready, 1'b1);
    step();
    dbus_valid = 0; mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h11;
    exp_rsp.push_back('{1'b0, 32'h11});
    sample();
    chkb("t5_ibus_rvalid", ibus_rvalid, 1'b1);
    step();
    dbus_rready = 0; mem_rdata = 32'h22;
    for (int k = 0; k < 2; k++) begin
      sample();
      chkb("t5_stall_dbus_rvalid", dbus_rvalid, 1'b1);
      chkb("t5_stall_rready", mem_rready, 1'b0);
      chkb("t5_stall_ibus_rvalid", ibus_rvalid, 1'b0);
      step();
    end
    dbus_rready = 1;
    exp_rsp.push_back('{1'b1, 32'h22});
    sample();
    chkb("t5_rready", mem_rready, 1'b1);
    step();
    mem_rvalid = 0;

    // 6: reset flushes outstanding read; stale response sets sticky err
    ibus_valid = 1; ibus_addr = 32'h700; mem_ready = 1;
    exp_req.push_back('{32'h700, 4'h0});
    step();
    ibus_valid = 0; mem_ready = 0; rst_n = 0;
    step();
    rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h99;
    sample();
    chkb("t6_rready", mem_rready, 1'b1);
    chkb("t6_ibus_rvalid", ibus_rvalid, 1'b0);
    chkb("t6_dbus_rvalid", dbus_rvalid, 1'b0);
    chkb("t6_err_pre", err, 1'b0);
    step();
    mem_rvalid = 0;
    sample();
    chkb("t6_err_set", err, 1'b1);
    step(); step();
    sample();
    chkb("t6_err_sticky", err, 1'b1);

    chk("req_queue_drained", exp_req.size(), 32'd0);
    chk("rsp_queue_drained", exp_rsp.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
